// File: rtl/z_pipe_csa.sv
// Pipelined carry-select adder/subtractor: K groups of M bits, a register after every G groups.
// Valid/ready on both ends; a stall at the output freezes every stage, bubbles included.
module z_pipe_csa #(
    parameter int K = 8,
    parameter int M = 4,
    parameter int G = 2,
    parameter int N = K * M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         ovf
);
    localparam int L = K / G;

    generate
        if ((K % G) != 0 || N != K * M) begin : g_param_err
            $error("z_pipe_csa: K must be a multiple of G and N must equal K*M");
        end
    endgenerate

    logic                r_init;
    logic                w_adv;
    logic                w_acc;
    logic [L-1:0]        r_v;
    logic [L-1:0]        w_nx_v;
    logic [L-1:0]        r_c;
    logic [L-1:0]        w_nx_c;
    logic [L-1:0][N-1:0] r_a;
    logic [L-1:0][N-1:0] r_b;
    logic [L-1:0][N-1:0] r_sum;
    logic [L-1:0][N-1:0] w_nx_a;
    logic [L-1:0][N-1:0] w_nx_b;
    logic [L-1:0][N-1:0] w_nx_sum;
    logic                r_ovf;
    logic                w_nx_ovf;
    logic                w_unused;

    assign w_adv    = !r_v[L-1] || out_ready;
    assign in_ready = r_init && w_adv;
    assign w_acc    = in_valid && in_ready;

    genvar s, g;
    generate
        for (s = 0; s < L; s++) begin : g_stage
            logic [N-1:0]   w_a_in;
            logic [N-1:0]   w_b_in;
            logic [N-1:0]   w_sum_in;
            logic [N-1:0]   w_sum_out;
            logic [G*M-1:0] w_grp;
            logic [G:0]     w_gc;
            logic           w_v_in;

            // Subtraction is folded in here: b inverted and carry forced, so later stages only add.
            if (s == 0) begin : g_first
                assign w_a_in   = a;
                assign w_b_in   = sub ? ~b : b;
                assign w_sum_in = '0;
                assign w_gc[0]  = sub ? 1'b1 : c_in;
                assign w_v_in   = w_acc;
            end else begin : g_next
                assign w_a_in   = r_a[s-1];
                assign w_b_in   = r_b[s-1];
                assign w_sum_in = r_sum[s-1];
                assign w_gc[0]  = r_c[s-1];
                assign w_v_in   = r_v[s-1];
            end

            for (g = 0; g < G; g++) begin : g_grp
                localparam int LSB = (s * G + g) * M;
                logic [M:0] w_s0;
                logic [M:0] w_s1;
                logic [M:0] w_sel;
                assign w_s0  = {1'b0, w_a_in[LSB +: M]} + {1'b0, w_b_in[LSB +: M]};
                assign w_s1  = {1'b0, w_a_in[LSB +: M]} + {1'b0, w_b_in[LSB +: M]} + {{M{1'b0}}, 1'b1};
                assign w_sel = w_gc[g] ? w_s1 : w_s0;
                assign w_grp[g*M +: M] = w_sel[M-1:0];
                assign w_gc[g+1]       = w_sel[M];
            end

            always_comb begin
                w_sum_out                  = w_sum_in;
                w_sum_out[s*G*M +: G*M]    = w_grp;
            end

            assign w_nx_a[s]   = w_a_in;
            assign w_nx_b[s]   = w_b_in;
            assign w_nx_sum[s] = w_sum_out;
            assign w_nx_c[s]   = w_gc[G];
            assign w_nx_v[s]   = w_v_in;

            // Carry into the MSB is recovered as a^b^sum at bit N-1.
            if (s == L - 1) begin : g_ovf
                assign w_nx_ovf = w_gc[G] ^ (w_a_in[N-1] ^ w_b_in[N-1] ^ w_sum_out[N-1]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init <= 1'b0;
            r_v    <= '0;
            r_c    <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_sum  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_init <= 1'b1;
            if (w_adv) begin
                r_v   <= w_nx_v;
                r_c   <= w_nx_c;
                r_a   <= w_nx_a;
                r_b   <= w_nx_b;
                r_sum <= w_nx_sum;
                r_ovf <= w_nx_ovf;
            end
        end
    end

    assign out_valid = r_v[L-1];
    assign sum       = r_sum[L-1];
    assign c_out     = r_c[L-1];
    assign ovf       = r_ovf;
    assign w_unused  = ^{r_a[L-1], r_b[L-1]};

endmodule

// File: tb/tb_z_pipe_csa.sv
// Directed and randomised bench for z_pipe_csa; the default configuration gets the directed
// steps, three alternate geometries are scoreboarded alongside it during the random phase.
module tb_z_pipe_csa;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sb;
        logic [31:0] s;
        logic        c;
        logic        o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        c_in = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  rdy;
    logic [3:0]  ov;
    logic [3:0]  co;
    logic [3:0]  of;
    logic [31:0] sm [4];

    int          checks = 0;
    int          errors = 0;
    logic        sb_en = 1'b0;
    exp_t        mem [4][16];
    int unsigned wp [4] = '{0, 0, 0, 0};
    int unsigned rp [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    z_pipe_csa #(.K(8), .M(4), .G(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .a(a), .b(b),
        .c_in(c_in), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready), .sum(sm[0]),
        .c_out(co[0]), .ovf(of[0]));
    z_pipe_csa #(.K(8), .M(4), .G(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .a(a), .b(b),
        .c_in(c_in), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready), .sum(sm[1]),
        .c_out(co[1]), .ovf(of[1]));
    z_pipe_csa #(.K(8), .M(4), .G(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .a(a), .b(b),
        .c_in(c_in), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready), .sum(sm[2]),
        .c_out(co[2]), .ovf(of[2]));
    z_pipe_csa #(.K(4), .M(8), .G(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]), .a(a), .b(b),
        .c_in(c_in), .sub(sub), .out_valid(ov[3]), .out_ready(out_ready), .sum(sm[3]),
        .c_out(co[3]), .ovf(of[3]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One operation on the default instance; n counts edges from the accept edge (inclusive).
    task automatic do_op(input logic [31:0] a_v, input logic [31:0] b_v, input logic ci, input logic sb,
                         input logic [31:0] es, input logic ec, input logic eo, input string tag);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; a = a_v; b = b_v; c_in = ci; sub = sb; out_ready = 1'b1;
        @(negedge clk);
        check({tag, " in_ready"}, 64'(rdy[0]), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!ov[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd4);
        check({tag, " sum"}, 64'(sm[0]), 64'(es));
        check({tag, " c_out"}, 64'(co[0]), 64'(ec));
        check({tag, " ovf"}, 64'(of[0]), 64'(eo));
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] bb;
        logic [32:0] t;
        if (sb_en) begin
            for (int i = 0; i < 4; i++) begin
                if (ov[i] && out_ready) begin
                    checks++;
                    assert (wp[i] != rp[i]) else begin
                        errors++;
                        $error("FAIL rand_extra dut%0d: observed result 0x%0h expected none", i, sm[i]);
                    end
                    if (wp[i] != rp[i]) begin
                        e = mem[i][rp[i] % 16];
                        checks++;
                        assert ({co[i], of[i], sm[i]} === {e.c, e.o, e.s}) else begin
                            errors++;
                            $error("FAIL rand_result dut%0d: observed c=%0b o=%0b s=0x%08h expected c=%0b o=%0b s=0x%08h",
                                   i, co[i], of[i], sm[i], e.c, e.o, e.s);
                        end
                        rp[i]++;
                    end
                end
                if (in_valid && rdy[i]) begin
                    bb  = sub ? ~b : b;
                    t   = {1'b0, a} + {1'b0, bb} + 33'(sub ? 1'b1 : c_in);
                    e.s = t[31:0];
                    e.c = t[32];
                    e.o = (a[31] == bb[31]) && (t[31] != a[31]);
                    mem[i][wp[i] % 16] = e;
                    wp[i]++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion expected completion before 1 ms");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tv [8];
        logic [32:0] snap;
        int          si;
        int          ri;
        int          acc;
        int          cyc;
        logic        stall;

        // Reset state
        @(posedge clk); #1;
        check("rst in_ready", 64'(rdy[0]), 64'd0);
        check("rst out_valid", 64'(ov[0]), 64'd0);
        check("rst sum", 64'(sm[0]), 64'd0);
        check("rst c_out", 64'(co[0]), 64'd0);
        check("rst ovf", 64'(of[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "t1 add wrap");
        do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "t2 sub borrow");
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "t3 add ovf");
        do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "t3 sub ovf");

        // Streaming with a 3-cycle output stall
        tv[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
        tv[1] = '{32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
        tv[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tv[3] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tv[4] = '{32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tv[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
        tv[6] = '{32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 32'h9999_999A, 1'b0, 1'b0};
        tv[7] = '{32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        si = 0;
        ri = 0;
        snap = '0;
        for (int k = 0; k < 40 && ri < 8; k++) begin
            @(posedge clk); #1;
            stall     = (k >= 6 && k <= 8);
            in_valid  = (si < 8);
            if (si < 8) begin
                a = tv[si].a; b = tv[si].b; c_in = tv[si].ci; sub = tv[si].sb;
            end
            out_ready = !stall;
            @(negedge clk);
            check($sformatf("t4 in_ready cyc%0d", k), 64'(rdy[0]), 64'(!stall));
            if (k == 6) begin
                check("t4 stall out_valid", 64'(ov[0]), 64'd1);
                snap = {co[0], sm[0]};
            end else if (stall) begin
                check($sformatf("t4 hold cyc%0d", k), 64'({co[0], sm[0]}), 64'(snap));
            end
            if (in_valid && rdy[0]) si++;
            if (ov[0] && out_ready) begin
                check($sformatf("t4 res%0d sum", ri), 64'(sm[0]), 64'(tv[ri].s));
                check($sformatf("t4 res%0d c_out", ri), 64'(co[0]), 64'(tv[ri].c));
                check($sformatf("t4 res%0d ovf", ri), 64'(of[0]), 64'(tv[ri].o));
                ri++;
            end
        end
        check("t4 results delivered", 64'(ri), 64'd8);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        check("t4 no extra result", 64'(ov[0]), 64'd0);

        // Asynchronous reset with operations in flight
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = 32'h10 + 32'(i); b = 32'h1; c_in = 1'b0; sub = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t5 pre out_valid", 64'(ov[0]), 64'd1);
        check("t5 pre sum", 64'(sm[0]), 64'h11);
        #1 rst_n = 1'b0;
        #1;
        check("t5 async out_valid", 64'(ov[0]), 64'd0);
        check("t5 async in_ready", 64'(rdy[0]), 64'd0);
        check("t5 async sum", 64'(sm[0]), 64'd0);
        check("t5 async c_out", 64'(co[0]), 64'd0);
        check("t5 async ovf", 64'(of[0]), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("t5 no stale cyc%0d", i), 64'(ov[0]), 64'd0);
        end
        do_op(32'h0000_0100, 32'h0000_0023, 1'b1, 1'b0, 32'h0000_0124, 1'b0, 1'b0, "t5 post reset");

        // Random traffic on all four geometries
        repeat (12) @(posedge clk);
        #1;
        sb_en = 1'b1;
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 40000) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
            b         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            c_in      = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && rdy[0]) acc++;
            cyc++;
        end
        check("t6 ops accepted", 64'(acc), 64'd10000);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6 dut%0d drained", i), 64'(wp[i]), 64'(rp[i]));
        end
        sb_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
